// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake, holds for decode, redirects on branches.
// Optional ack watchdog is built when IF_FETCH_TIMEOUT_EN is defined; otherwise fetch_err is tied to 0.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic        valid,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] redirect_r, redirect_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] pc_out_r, pc_out_s;
    logic        valid_r, valid_s;
    logic        req_r, req_s;
    logic [31:0] target_s;

    assign target_s = branch_addr & 32'hFFFF_FFFC;

    // Next-state and next-register-value logic for the fetch FSM.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        redirect_s = redirect_r;
        instr_s    = instr_r;
        pc_out_s   = pc_out_r;
        valid_s    = valid_r;
        case (state_r)
            IDLE: begin
                state_s = FETCH;
            end
            FETCH: begin
                if (imem_ack && !branch_taken) begin
                    instr_s  = imem_rdata;
                    pc_out_s = pc_r + 32'd4;
                    pc_s     = pc_r + 32'd4;
                    valid_s  = 1'b1;
                    state_s  = HOLD;
                end else if (imem_ack) begin
                    pc_s = target_s;
                end else if (branch_taken) begin
                    redirect_s = target_s;
                    state_s    = DRAIN;
                end else begin
                    state_s = FETCH;
                end
            end
            DRAIN: begin
                // Stale request must complete on its old address before the redirect goes out.
                if (imem_ack) begin
                    pc_s    = branch_taken ? target_s : redirect_r;
                    state_s = FETCH;
                end else if (branch_taken) begin
                    redirect_s = target_s;
                end else begin
                    state_s = DRAIN;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    valid_s = 1'b0;
                    pc_s    = target_s;
                    state_s = FETCH;
                end else if (freeze) begin
                    state_s = HOLD;
                end else begin
                    valid_s = 1'b0;
                    state_s = FETCH;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        req_s = (state_s == FETCH) || (state_s == DRAIN);
    end

    // Fetch state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            redirect_r <= 32'd0;
            instr_r    <= 32'd0;
            pc_out_r   <= 32'd0;
            valid_r    <= 1'b0;
            req_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            redirect_r <= redirect_s;
            instr_r    <= instr_s;
            pc_out_r   <= pc_out_s;
            valid_r    <= valid_s;
            req_r      <= req_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign Instruction = instr_r;
    assign PC          = pc_out_r;
    assign valid       = valid_r;

`ifdef IF_FETCH_TIMEOUT_EN
    logic [31:0] to_cnt_r;
    logic        err_r;
    logic        waiting_s;

    assign waiting_s = ((state_r == FETCH) || (state_r == DRAIN)) && !imem_ack;

    // Watchdog: counts consecutive un-acked request cycles; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= 32'd0;
            err_r    <= 1'b0;
        end else if (waiting_s) begin
            if (to_cnt_r != 32'(TIMEOUT_CYCLES)) begin
                to_cnt_r <= to_cnt_r + 32'd1;
            end else begin
                to_cnt_r <= to_cnt_r;
            end
            if (to_cnt_r + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end else begin
            to_cnt_r <= 32'd0;
            err_r    <= err_r;
        end
    end

    assign fetch_err = err_r;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven directed bench for if_fetch_stage plus hand-written watchdog and reset sequences.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic        valid;
    logic        fetch_err;

    int n_cmp = 0;
    int n_err = 0;

`ifdef IF_FETCH_TIMEOUT_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    localparam logic [31:0] A0   = 32'h1111_0000;
    localparam logic [31:0] A1   = 32'h2222_0001;
    localparam logic [31:0] I5   = 32'h2001_0005;
    localparam logic [31:0] A3   = 32'h3333_0003;
    localparam logic [31:0] B0   = 32'h4444_0000;
    localparam logic [31:0] B1   = 32'h5555_0001;
    localparam logic [31:0] B2   = 32'h6666_0002;
    localparam logic [31:0] B3   = 32'h7777_0003;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    if_fetch_stage #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .Instruction  (Instruction),
        .PC           (PC),
        .valid        (valid),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fr;
        logic        br;
        logic [31:0] baddr;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fr, input logic br, input logic [31:0] baddr,
                       input logic ack, input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.fr = fr; v.br = br; v.baddr = baddr; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic br, input logic [31:0] baddr,
                         input logic ack, input logic [31:0] rdata);
        freeze       = fr;
        branch_taken = br;
        branch_addr  = baddr;
        imem_ack     = ack;
        imem_rdata   = rdata;
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_req",   idx, {31'd0, imem_req},  32'd0);
        chk("rst_addr",  idx, imem_addr,          32'h0000_0000);
        chk("rst_valid", idx, {31'd0, valid},     32'd0);
        chk("rst_pc",    idx, PC,                 32'd0);
        chk("rst_instr", idx, Instruction,        32'd0);
        chk("rst_err",   idx, {31'd0, fetch_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        //   fr    br    baddr          ack   rdata | req   addr           valid PC            Instruction
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 32'h0,        32'h0); // IDLE
        add(1'b0, 1'b0, 32'h0,         1'b1, A0,     1'b1, 32'h0,         1'b0, 32'h0,        32'h0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h4,         1'b1, 32'h4,        A0);
        add(1'b0, 1'b0, 32'h0,         1'b1, A1,     1'b1, 32'h4,         1'b0, 32'h4,        A0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h8,         1'b1, 32'h8,        A1);
        add(1'b0, 1'b0, 32'h0,         1'b1, I5,     1'b1, 32'h8,         1'b0, 32'h8,        A1);
        for (int i = 0; i < 5; i++)
            add(1'b1, 1'b0, 32'h0,     1'b0, 32'h0,  1'b0, 32'hC,         1'b1, 32'hC,        I5);    // freeze
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'hC,         1'b1, 32'hC,        I5);
        add(1'b0, 1'b0, 32'h0,         1'b1, A3,     1'b1, 32'hC,         1'b0, 32'hC,        I5);
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h10,        1'b1, 32'h10,       A3);
        add(1'b0, 1'b1, 32'h43,        1'b0, 32'h0,  1'b1, 32'h10,        1'b0, 32'h10,       A3);    // branch, no ack
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b1, 32'h10,        1'b0, 32'h10,       A3);
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b1, 32'h10,        1'b0, 32'h10,       A3);
        add(1'b0, 1'b0, 32'h0,         1'b1, DEAD,   1'b1, 32'h10,        1'b0, 32'h10,       A3);    // stale ack
        add(1'b0, 1'b1, 32'h100,       1'b1, DEAD,   1'b1, 32'h40,        1'b0, 32'h10,       A3);    // branch with ack
        add(1'b0, 1'b0, 32'h0,         1'b1, B0,     1'b1, 32'h100,       1'b0, 32'h10,       A3);
        add(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,  1'b0, 32'h104,       1'b1, 32'h104,      B0);    // branch beats freeze
        add(1'b0, 1'b0, 32'h0,         1'b1, B1,     1'b1, 32'hFFFF_FFFC, 1'b0, 32'h104,      B0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h0,         1'b1, 32'h0,        B1);    // wrap
        add(1'b0, 1'b1, 32'h200,       1'b0, 32'h0,  1'b1, 32'h0,         1'b0, 32'h0,        B1);
        add(1'b0, 1'b1, 32'h300,       1'b0, 32'h0,  1'b1, 32'h0,         1'b0, 32'h0,        B1);    // newest target
        add(1'b0, 1'b0, 32'h0,         1'b1, DEAD,   1'b1, 32'h0,         1'b0, 32'h0,        B1);
        add(1'b0, 1'b1, 32'h500,       1'b0, 32'h0,  1'b1, 32'h300,       1'b0, 32'h0,        B1);
        add(1'b0, 1'b1, 32'h601,       1'b1, DEAD,   1'b1, 32'h300,       1'b0, 32'h0,        B1);    // drain ack+branch
        add(1'b0, 1'b0, 32'h0,         1'b1, B2,     1'b1, 32'h600,       1'b0, 32'h0,        B1);
        add(1'b1, 1'b0, 32'h0,         1'b1, DEAD,   1'b0, 32'h604,       1'b1, 32'h604,      B2);    // ack without req
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,  1'b0, 32'h604,       1'b1, 32'h604,      B2);

        repeat (2) @(negedge clk);
        chk_reset(0);

        rst = 1'b1;
        foreach (vecs[i]) begin
            chk("req",   i, {31'd0, vecs[i].e_req},  {31'd0, imem_req});
            chk("addr",  i, imem_addr,   vecs[i].e_addr);
            chk("valid", i, {31'd0, valid},     {31'd0, vecs[i].e_valid});
            chk("pc",    i, PC,          vecs[i].e_pc);
            chk("instr", i, Instruction, vecs[i].e_instr);
            chk("err",   i, {31'd0, fetch_err}, 32'd0);
            drive(vecs[i].fr, vecs[i].br, vecs[i].baddr, vecs[i].ack, vecs[i].rdata);
            @(negedge clk);
        end

        // Withhold ack for 16 request cycles.
        for (int i = 0; i < 16; i++) begin
            chk("wd_req",  i, {31'd0, imem_req},  32'd1);
            chk("wd_addr", i, imem_addr,          32'h604);
            chk("wd_err",  i, {31'd0, fetch_err}, 32'd0);
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
        end
        chk("wd_err_set", 0, {31'd0, fetch_err}, {31'd0, EXP_ERR});
        chk("wd_req_on",  0, {31'd0, imem_req},  32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, B3);
        @(negedge clk);
        chk("wd_valid", 0, {31'd0, valid},     32'd1);
        chk("wd_pc",    0, PC,                 32'h608);
        chk("wd_instr", 0, Instruction,        B3);
        chk("wd_sticky",0, {31'd0, fetch_err}, {31'd0, EXP_ERR});
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("mid_req",  0, {31'd0, imem_req},  32'd1);
        chk("mid_addr", 0, imem_addr,          32'h608);

        // Reset while a request is outstanding clears everything immediately.
        rst = 1'b0;
        #1;
        chk_reset(1);
        @(negedge clk);
        rst = 1'b1;
        chk_reset(2);
        @(negedge clk);
        chk("rel_req",  0, {31'd0, imem_req}, 32'd1);
        chk("rel_addr", 0, imem_addr,         32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
